// File: rtl/exe_lsu_stage.sv
// EXE-stage load/store slice: forms vaddr, issues the data_sram request, hands the op to MEM.
// Latency: one stage register; the op goes to MEM in the same cycle its address is accepted.
// Backpressure: holds the op while the request waits for addr_ok or MEM refuses it.
//
// Ports:
//   clk, reset (synchronous, active-high)
//   ID_*            op from ID, loaded when EXE_allowin & ID_to_EXE_valid
//   EXE_*           registered op plus vaddr/exception info towards MEM
//   data_sram_*     SRAM-like request channel (req/addr_ok) and response strobe (data_ok)
//   data_ok_discard marks a data_ok belonging to an op killed by exec_flush
//   exec_flush      exception/ertn flush from WB
// Optional feature: define EXE_ALE_CHECK_EN to trap misaligned half/word accesses
// in this stage instead of issuing them.
module exe_lsu_stage #(
    parameter int OUTS_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_to_EXE_valid,
    output logic        EXE_allowin,
    input  logic        ID_ld_en,
    input  logic        ID_st_en,
    input  logic        ID_op_b,
    input  logic        ID_op_h,
    input  logic        ID_op_unsigned_ld,
    input  logic [31:0] ID_base,
    input  logic [31:0] ID_offset,
    input  logic [31:0] ID_st_data,
    input  logic [31:0] ID_pc,
    input  logic [4:0]  ID_dest,
    input  logic        ID_gr_we,
    input  logic        MEM_allowin,
    output logic        EXE_to_MEM_valid,
    output logic [31:0] EXE_mem_pc,
    output logic [31:0] EXE_alu_result,
    output logic [4:0]  EXE_dest,
    output logic        EXE_gr_we,
    output logic        EXE_res_from_mem,
    output logic        EXE_mem_we,
    output logic        EXE_op_b,
    output logic        EXE_op_h,
    output logic        EXE_op_unsigned_ld,
    output logic [1:0]  EXE_vaddr_lo,
    output logic        EXE_ex_ale,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        data_ok_discard,
    input  logic        exec_flush
);

    localparam logic [OUTS_W-1:0] L_ONE = {{(OUTS_W-1){1'b0}}, 1'b1};

    logic              r_valid;
    logic              r_ld_en;
    logic              r_st_en;
    logic              r_op_b;
    logic              r_op_h;
    logic              r_op_unsigned_ld;
    logic [31:0]       r_base;
    logic [31:0]       r_offset;
    logic [31:0]       r_st_data;
    logic [31:0]       r_pc;
    logic [4:0]        r_dest;
    logic              r_gr_we;
    logic              r_req_sent;
    logic [OUTS_W-1:0] r_outs_cnt;
    logic [OUTS_W-1:0] r_discard_cnt;

    logic [31:0]       w_vaddr;
    logic              w_mem_op;
    logic              w_op_w;
    logic              w_ex_ale;
    logic              w_hs;
    logic              w_ready_go;
    logic              w_advance;
    logic              w_discard_zero;
    logic [OUTS_W-1:0] w_hs_inc;
    logic [OUTS_W-1:0] w_dok_dec;

    assign w_vaddr        = r_base + r_offset;
    assign w_mem_op       = r_ld_en | r_st_en;
    assign w_op_w         = ~r_op_b & ~r_op_h;
    assign w_discard_zero = (r_discard_cnt == '0);

`ifdef EXE_ALE_CHECK_EN
    assign w_ex_ale = r_valid & w_mem_op &
                      ((r_op_h & w_vaddr[0]) | (w_op_w & (w_vaddr[1:0] != 2'b00)));
`else
    assign w_ex_ale = 1'b0;
`endif

    // Request is only raised when no stale responses are still owed to flushed ops,
    // so every data_ok seen with discard_cnt==0 belongs to a live op.
    assign data_sram_req = r_valid & w_mem_op & ~w_ex_ale & ~r_req_sent & ~exec_flush
                         & w_discard_zero;
    assign w_hs          = data_sram_req & data_sram_addr_ok;

    assign w_ready_go       = ~w_mem_op | w_ex_ale | r_req_sent | w_hs;
    assign EXE_allowin      = ~r_valid | (w_ready_go & MEM_allowin);
    assign EXE_to_MEM_valid = r_valid & w_ready_go & ~exec_flush;
    assign w_advance        = r_valid & w_ready_go & MEM_allowin;

    assign data_ok_discard  = data_sram_data_ok & ~w_discard_zero;

    assign w_hs_inc  = w_hs ? L_ONE : '0;
    assign w_dok_dec = data_sram_data_ok ? L_ONE : '0;

    // Request payload depends only on the stage register, so it stays stable
    // while the stage stalls waiting for addr_ok.
    always_comb begin
        data_sram_size  = 2'd2;
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = r_st_data;
        if (r_op_b) begin
            data_sram_size  = 2'd0;
            data_sram_wdata = {4{r_st_data[7:0]}};
            if (r_st_en) data_sram_wstrb = 4'b0001 << w_vaddr[1:0];
        end else if (r_op_h) begin
            data_sram_size  = 2'd1;
            data_sram_wdata = {2{r_st_data[15:0]}};
            if (r_st_en) data_sram_wstrb = w_vaddr[1] ? 4'b1100 : 4'b0011;
        end else if (w_op_w) begin
            if (r_st_en) data_sram_wstrb = 4'b1111;
        end
    end

    assign data_sram_wr   = r_st_en;
    assign data_sram_addr = w_vaddr;

    assign EXE_mem_pc         = r_pc;
    assign EXE_alu_result     = w_mem_op ? w_vaddr : r_base;
    assign EXE_dest           = r_dest;
    assign EXE_gr_we          = r_gr_we;
    assign EXE_res_from_mem   = r_ld_en;
    assign EXE_mem_we         = r_st_en;
    assign EXE_op_b           = r_op_b;
    assign EXE_op_h           = r_op_h;
    assign EXE_op_unsigned_ld = r_op_unsigned_ld;
    assign EXE_vaddr_lo       = w_vaddr[1:0];
    assign EXE_ex_ale         = w_ex_ale;

    // Stage register; flush wins over a simultaneous load from ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid          <= 1'b0;
            r_ld_en          <= 1'b0;
            r_st_en          <= 1'b0;
            r_op_b           <= 1'b0;
            r_op_h           <= 1'b0;
            r_op_unsigned_ld <= 1'b0;
            r_base           <= '0;
            r_offset         <= '0;
            r_st_data        <= '0;
            r_pc             <= '0;
            r_dest           <= '0;
            r_gr_we          <= 1'b0;
        end else begin
            if (exec_flush)       r_valid <= 1'b0;
            else if (EXE_allowin) r_valid <= ID_to_EXE_valid;
            if (EXE_allowin && ID_to_EXE_valid && !exec_flush) begin
                r_ld_en          <= ID_ld_en;
                r_st_en          <= ID_st_en;
                r_op_b           <= ID_op_b;
                r_op_h           <= ID_op_h;
                r_op_unsigned_ld <= ID_op_unsigned_ld;
                r_base           <= ID_base;
                r_offset         <= ID_offset;
                r_st_data        <= ID_st_data;
                r_pc             <= ID_pc;
                r_dest           <= ID_dest;
                r_gr_we          <= ID_gr_we;
            end
        end
    end

    // Remembers an accepted address while MEM is stalled so it is not re-issued.
    always_ff @(posedge clk) begin
        if (reset || exec_flush) r_req_sent <= 1'b0;
        else if (w_advance)      r_req_sent <= 1'b0;
        else if (w_hs)           r_req_sent <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) r_outs_cnt <= '0;
        else       r_outs_cnt <= r_outs_cnt + w_hs_inc - w_dok_dec;
    end

    // On flush, every response still owed (minus one arriving now) is stale.
    always_ff @(posedge clk) begin
        if (reset)                                   r_discard_cnt <= '0;
        else if (exec_flush)                         r_discard_cnt <= r_outs_cnt + w_hs_inc - w_dok_dec;
        else if (data_sram_data_ok && !w_discard_zero) r_discard_cnt <= r_discard_cnt - L_ONE;
    end

endmodule

// File: tb/tb_exe_lsu_stage.sv
module tb_exe_lsu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_to_EXE_valid;
    logic        EXE_allowin;
    logic        ID_ld_en, ID_st_en, ID_op_b, ID_op_h, ID_op_unsigned_ld;
    logic [31:0] ID_base, ID_offset, ID_st_data, ID_pc;
    logic [4:0]  ID_dest;
    logic        ID_gr_we;
    logic        MEM_allowin;
    logic        EXE_to_MEM_valid;
    logic [31:0] EXE_mem_pc, EXE_alu_result;
    logic [4:0]  EXE_dest;
    logic        EXE_gr_we, EXE_res_from_mem, EXE_mem_we;
    logic        EXE_op_b, EXE_op_h, EXE_op_unsigned_ld;
    logic [1:0]  EXE_vaddr_lo;
    logic        EXE_ex_ale;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic        data_ok_discard;
    logic        exec_flush;

    always #5 clk = ~clk;

    exe_lsu_stage #(.OUTS_W(2)) dut (
        .clk(clk), .reset(reset),
        .ID_to_EXE_valid(ID_to_EXE_valid), .EXE_allowin(EXE_allowin),
        .ID_ld_en(ID_ld_en), .ID_st_en(ID_st_en), .ID_op_b(ID_op_b), .ID_op_h(ID_op_h),
        .ID_op_unsigned_ld(ID_op_unsigned_ld), .ID_base(ID_base), .ID_offset(ID_offset),
        .ID_st_data(ID_st_data), .ID_pc(ID_pc), .ID_dest(ID_dest), .ID_gr_we(ID_gr_we),
        .MEM_allowin(MEM_allowin), .EXE_to_MEM_valid(EXE_to_MEM_valid),
        .EXE_mem_pc(EXE_mem_pc), .EXE_alu_result(EXE_alu_result), .EXE_dest(EXE_dest),
        .EXE_gr_we(EXE_gr_we), .EXE_res_from_mem(EXE_res_from_mem), .EXE_mem_we(EXE_mem_we),
        .EXE_op_b(EXE_op_b), .EXE_op_h(EXE_op_h), .EXE_op_unsigned_ld(EXE_op_unsigned_ld),
        .EXE_vaddr_lo(EXE_vaddr_lo), .EXE_ex_ale(EXE_ex_ale),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_ok_discard(data_ok_discard), .exec_flush(exec_flush)
    );

    typedef struct packed {
        logic        ld, st, b, h, uns;
        logic [31:0] base, off, sd, pc;
        logic [4:0]  dest;
        logic        gr_we;
    } op_t;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the op sitting in EXE, whether its address was already
    // accepted, and one entry per response still owed (1 = owed to a flushed op).
    logic m_v;
    op_t  m_op;
    logic m_acc;
    bit   inflight[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input int kind, input int sz, input logic uns,
                               input logic [31:0] base, input logic [31:0] off,
                               input logic [31:0] sd);
        op_t o;
        o.ld = (kind == 1); o.st = (kind == 2);
        o.b = (sz == 0); o.h = (sz == 1); o.uns = uns;
        o.base = base; o.off = off; o.sd = sd;
        o.pc = base ^ 32'h8000_0040; o.dest = off[4:0] ^ 5'd7; o.gr_we = (kind != 2);
        return o;
    endfunction

    function automatic int nbytes(input op_t o);
        return o.b ? 1 : (o.h ? 2 : 4);
    endfunction

    function automatic logic misaligned(input op_t o);
`ifdef EXE_ALE_CHECK_EN
        logic [31:0] va;
        va = o.base + o.off;
        return (o.ld || o.st) && ((va % nbytes(o)) != 0);
`else
        return (o.ld && o.st);
`endif
    endfunction

    function automatic logic [3:0] exp_strb(input op_t o);
        logic [31:0] va;
        int n;
        va = o.base + o.off;
        n = nbytes(o);
        if (!o.st) return 4'b0000;
        // lanes covered by an n-byte access starting at the naturally aligned slot
        return 4'((2 ** n - 1) << ((va % 4) / n * n));
    endfunction

    function automatic logic [31:0] exp_wdata(input op_t o);
        if (o.b) return {24'd0, o.sd[7:0]} * 32'h0101_0101;
        if (o.h) return {16'd0, o.sd[15:0]} * 32'h0001_0001;
        return o.sd;
    endfunction

    task automatic step(input logic idv, input op_t op, input logic mal,
                        input logic aok, input logic dok, input logic fl);
        logic [31:0] va;
        logic mem, a, killed, ereq, hs, done, eto, eall, edisc;
        @(negedge clk);
        ID_to_EXE_valid = idv;
        ID_ld_en = op.ld; ID_st_en = op.st; ID_op_b = op.b; ID_op_h = op.h;
        ID_op_unsigned_ld = op.uns; ID_base = op.base; ID_offset = op.off;
        ID_st_data = op.sd; ID_pc = op.pc; ID_dest = op.dest; ID_gr_we = op.gr_we;
        MEM_allowin = mal; data_sram_addr_ok = aok; data_sram_data_ok = dok; exec_flush = fl;
        #1;
        va = m_op.base + m_op.off;
        mem = m_op.ld | m_op.st;
        a = m_v && misaligned(m_op);
        killed = 1'b0;
        foreach (inflight[i]) if (inflight[i]) killed = 1'b1;
        ereq = m_v && mem && !a && !m_acc && !fl && !killed;
        hs = ereq && aok;
        done = !mem || a || m_acc || hs;
        eto = m_v && done && !fl;
        eall = !m_v || (done && mal);
        edisc = dok && (inflight.size() > 0) && inflight[0];
        chk("req", data_sram_req, ereq);
        chk("to_mem_valid", EXE_to_MEM_valid, eto);
        chk("allowin", EXE_allowin, eall);
        chk("discard", data_ok_discard, edisc);
        if (ereq) begin
            chk("addr", data_sram_addr, va);
            chk("wr", data_sram_wr, m_op.st);
            chk("size", data_sram_size, m_op.b ? 0 : (m_op.h ? 1 : 2));
            chk("wstrb", data_sram_wstrb, exp_strb(m_op));
            chk("wdata", data_sram_wdata, exp_wdata(m_op));
        end
        if (eto) begin
            chk("alu_result", EXE_alu_result, mem ? va : m_op.base);
            chk("pc", EXE_mem_pc, m_op.pc);
            chk("dest", EXE_dest, m_op.dest);
            chk("gr_we", EXE_gr_we, m_op.gr_we);
            chk("res_from_mem", EXE_res_from_mem, m_op.ld);
            chk("mem_we", EXE_mem_we, m_op.st);
            chk("op_b", EXE_op_b, m_op.b);
            chk("op_h", EXE_op_h, m_op.h);
            chk("op_uns", EXE_op_unsigned_ld, m_op.uns);
            chk("vaddr_lo", EXE_vaddr_lo, va % 4);
            chk("ex_ale", EXE_ex_ale, a);
        end
        if (dok && inflight.size() > 0) void'(inflight.pop_front());
        if (hs) inflight.push_back(1'b0);
        if (fl) foreach (inflight[i]) inflight[i] = 1'b1;
        if (fl) begin
            m_v = 1'b0; m_acc = 1'b0;
        end else if (eall) begin
            m_v = idv; m_acc = 1'b0;
            if (idv) m_op = op;
        end else if (hs) begin
            m_acc = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        ID_to_EXE_valid = 1'b0; MEM_allowin = 1'b0; data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0; exec_flush = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_v = 1'b0; m_acc = 1'b0; m_op = '0; inflight.delete();
        #1;
    endtask

    initial begin
        op_t nop, o, o2, o3, o4;
        nop = '0;
        reset = 1'b1;
        ID_to_EXE_valid = 1'b0; {ID_ld_en, ID_st_en, ID_op_b, ID_op_h, ID_op_unsigned_ld} = '0;
        ID_base = '0; ID_offset = '0; ID_st_data = '0; ID_pc = '0; ID_dest = '0; ID_gr_we = 1'b0;
        MEM_allowin = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; exec_flush = 1'b0;
        m_v = 1'b0; m_acc = 1'b0; m_op = '0;
        repeat (2) @(posedge clk);
        apply_reset();
        chk("rst_req", data_sram_req, 0);
        chk("rst_to_mem", EXE_to_MEM_valid, 0);
        chk("rst_allowin", EXE_allowin, 1);

        // ld.w 0x1000+4, accepted immediately
        o = mk(1, 2, 0, 32'h1000, 32'd4, 32'd0);
        step(1, o, 1, 0, 0, 0);
        step(0, nop, 1, 1, 0, 0);
        chk("t1_req", data_sram_req, 1);
        chk("t1_addr", data_sram_addr, 32'h1004);
        chk("t1_size", data_sram_size, 2);
        chk("t1_wr", data_sram_wr, 0);
        chk("t1_to_mem", EXE_to_MEM_valid, 1);
        step(0, nop, 1, 0, 1, 0);
        chk("t1_keep", data_ok_discard, 0);

        // st.b to byte 3
        o = mk(2, 0, 0, 32'h2000, 32'd3, 32'h0000_00A5);
        step(1, o, 1, 0, 0, 0);
        step(0, nop, 1, 1, 0, 0);
        chk("t2_wstrb", data_sram_wstrb, 4'b1000);
        chk("t2_wdata", data_sram_wdata, 32'hA5A5_A5A5);
        chk("t2_size", data_sram_size, 0);
        chk("t2_wr", data_sram_wr, 1);
        step(0, nop, 1, 0, 1, 0);

        // addr_ok late, MEM stalled at the handshake
        o = mk(1, 2, 0, 32'h3000, 32'd8, 32'd0);
        step(1, o, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, nop, 0, 0, 0, 0);
            chk("t3_req_wait", data_sram_req, 1);
            chk("t3_addr_wait", data_sram_addr, 32'h3008);
        end
        step(0, nop, 0, 1, 0, 0);
        chk("t3_req_hs", data_sram_req, 1);
        chk("t3_allowin_hs", EXE_allowin, 0);
        step(0, nop, 0, 1, 0, 0);
        chk("t3_no_2nd_req", data_sram_req, 0);
        chk("t3_to_mem_held", EXE_to_MEM_valid, 1);
        step(0, nop, 1, 0, 0, 0);
        chk("t3_advance", EXE_allowin, 1);
        step(0, nop, 0, 0, 1, 0);

        // two loads in flight, flush, then both responses discarded
        o  = mk(1, 2, 0, 32'h4000, 32'd0, 32'd0);
        o2 = mk(1, 2, 0, 32'h4010, 32'd0, 32'd0);
        o3 = mk(1, 2, 0, 32'h4020, 32'd0, 32'd0);
        o4 = mk(1, 2, 1, 32'h4030, 32'd4, 32'd0);
        step(1, o, 1, 0, 0, 0);
        step(1, o2, 1, 1, 0, 0);
        step(1, o3, 1, 1, 0, 0);
        step(0, nop, 1, 0, 0, 1);
        chk("t4_flush_req", data_sram_req, 0);
        chk("t4_flush_to_mem", EXE_to_MEM_valid, 0);
        step(1, o4, 1, 0, 0, 0);
        step(0, nop, 1, 1, 0, 0);
        chk("t4_req_held", data_sram_req, 0);
        step(0, nop, 1, 1, 1, 0);
        chk("t4_discard_1", data_ok_discard, 1);
        chk("t4_req_held_1", data_sram_req, 0);
        step(0, nop, 1, 1, 1, 0);
        chk("t4_discard_2", data_ok_discard, 1);
        chk("t4_req_held_2", data_sram_req, 0);
        step(0, nop, 1, 1, 0, 0);
        chk("t4_req_free", data_sram_req, 1);
        step(0, nop, 1, 0, 1, 0);
        chk("t4_live_resp", data_ok_discard, 0);

        // ld.h at odd address
        o = mk(1, 1, 0, 32'h1000, 32'd1, 32'd0);
        step(1, o, 1, 0, 0, 0);
        step(0, nop, 1, 1, 0, 0);
`ifdef EXE_ALE_CHECK_EN
        chk("t5_ale_noreq", data_sram_req, 0);
        chk("t5_ale_flag", EXE_ex_ale, 1);
        chk("t5_ale_addr", EXE_alu_result, 32'h1001);
        chk("t5_ale_to_mem", EXE_to_MEM_valid, 1);
`else
        chk("t5_req", data_sram_req, 1);
        chk("t5_addr", data_sram_addr, 32'h1001);
        step(0, nop, 1, 0, 1, 0);
`endif

        // reset with one response owed and a request pending
        o  = mk(1, 2, 0, 32'h5000, 32'd0, 32'd0);
        o2 = mk(2, 2, 0, 32'h5004, 32'd0, 32'h1234_5678);
        o3 = mk(1, 0, 1, 32'h5008, 32'd1, 32'd0);
        step(1, o, 1, 0, 0, 0);
        step(1, o2, 1, 1, 0, 0);
        step(0, nop, 1, 0, 0, 0);
        chk("t6_pending", data_sram_req, 1);
        apply_reset();
        chk("t6_rst_req", data_sram_req, 0);
        chk("t6_rst_to_mem", EXE_to_MEM_valid, 0);
        chk("t6_rst_allowin", EXE_allowin, 1);
        step(0, nop, 1, 0, 0, 1);
        step(1, o3, 1, 0, 0, 0);
        step(0, nop, 1, 1, 0, 0);
        chk("t6_cnt_cleared", data_sram_req, 1);
        step(0, nop, 1, 0, 1, 0);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic idv, mal, aok, dok, fl;
            int kind, sz;
            kind = $urandom_range(0, 2);
            sz   = $urandom_range(0, 2);
            o = mk(kind, sz, 1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(0, 9)), $urandom);
            idv = ($urandom_range(0, 3) != 0);
            mal = ($urandom_range(0, 2) != 0);
            aok = (inflight.size() < 2) && ($urandom_range(0, 1) == 1);
            dok = (inflight.size() > 0) && ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            step(idv, o, mal, aok, dok, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
